// File: rtl/u8acc_pack.sv
// u8acc_pack: packs u8 results from u8mac into little-endian 32-bit words with
// byte strobes, queues them in a small FIFO and issues them over a valid/ready port.
module u8acc_pack #(
    parameter int AW    = 24,
    parameter int DEPTH = 8,
    parameter int AFULL = 2
) (
    input  logic          clk,
    input  logic          xreset,
    input  logic          start,
    input  logic [AW-1:0] base_adr,
    input  logic [AW-1:0] out_len,
    input  logic          acvalid,
    input  logic [7:0]    accd,
    output logic          wvalid,
    input  logic          wready,
    output logic [AW-3:0] wadr,
    output logic [31:0]   wdata,
    output logic [3:0]    wstrb,
    output logic          afull,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = (AW - 2) + 32 + 4;
    localparam int AF_TH = (DEPTH > AFULL) ? (DEPTH - AFULL) : 0;

    localparam logic [AW-1:0] ADR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADR_ZERO  = {AW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(AF_TH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [AW-1:0]   remain_q, remain_d;
    logic [31:0]     pack_q, pack_d;
    logic [3:0]      strb_q, strb_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            afull_q, afull_d;
    logic            ovf_q, ovf_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic [1:0]      lane_s;
    logic [31:0]     pack_merged_s;
    logic [3:0]      strb_merged_s;
    logic            last_s;
    logic            push_s;
    logic            push_ok_s;
    logic            pop_s;
    logic            full_s;
    logic            drop_s;
    logic            start_acc_s;
    logic [EW-1:0]   entry_s;
    logic [EW-1:0]   head_s;

    // Byte merge into the pack register at the lane selected by the low address bits
    always_comb begin
        lane_s        = adr_q[1:0];
        pack_merged_s = pack_q;
        case (lane_s)
            2'd0:    pack_merged_s[7:0]   = accd;
            2'd1:    pack_merged_s[15:8]  = accd;
            2'd2:    pack_merged_s[23:16] = accd;
            2'd3:    pack_merged_s[31:24] = accd;
            default: pack_merged_s        = pack_q;
        endcase
        strb_merged_s = strb_q | (4'b0001 << lane_s);
        last_s        = (remain_q == ADR_ONE);
    end

    // Sequencing FSM, address/length tracking and word assembly
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        remain_d    = remain_q;
        pack_d      = pack_q;
        strb_d      = strb_q;
        push_s      = 1'b0;
        start_acc_s = 1'b0;
        entry_s     = {adr_q[AW-1:2], pack_merged_s, strb_merged_s};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    adr_d       = base_adr;
                    remain_d    = out_len;
                    pack_d      = 32'h0000_0000;
                    strb_d      = 4'b0000;
                    state_d     = (out_len != ADR_ZERO) ? ST_RUN : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (acvalid) begin
                    adr_d    = adr_q + ADR_ONE;
                    remain_d = remain_q - ADR_ONE;
                    if ((lane_s == 2'd3) || last_s) begin
                        push_s = 1'b1;
                        pack_d = 32'h0000_0000;
                        strb_d = 4'b0000;
                    end else begin
                        pack_d = pack_merged_s;
                        strb_d = strb_merged_s;
                    end
                    state_d = last_s ? ST_FLUSH : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Leave as soon as the final pop empties the FIFO so done follows it directly
                if ((count_q == CNT_ZERO) || ((count_q == CNT_ONE) && pop_s)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; a push into a full FIFO survives only if a pop frees the head slot
    always_comb begin
        pop_s     = (count_q != CNT_ZERO) && wready;
        full_s    = (count_q == CNT_FULL);
        push_ok_s = push_s && (!full_s || pop_s);
        drop_s    = push_s && full_s && !pop_s;
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        if (push_ok_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_s && !push_ok_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
        afull_d = (count_d >= CNT_AFULL);
        if (start_acc_s) begin
            ovf_d = 1'b0;
        end else if (drop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!xreset) begin
            state_q  <= ST_IDLE;
            adr_q    <= ADR_ZERO;
            remain_q <= ADR_ZERO;
            pack_q   <= 32'h0000_0000;
            strb_q   <= 4'b0000;
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= CNT_ZERO;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            remain_q <= remain_d;
            pack_q   <= pack_d;
            strb_q   <= strb_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset since the count gates every output
    always_ff @(posedge clk) begin
        if (xreset && push_ok_s) begin
            mem_q[wr_ptr_q] <= entry_s;
        end
    end

    assign head_s = mem_q[rd_ptr_q];
    assign wvalid = (count_q != CNT_ZERO);
    assign wadr   = wvalid ? head_s[EW-1:36] : {(AW-2){1'b0}};
    assign wdata  = wvalid ? head_s[35:4]    : 32'h0000_0000;
    assign wstrb  = wvalid ? head_s[3:0]     : 4'b0000;
    assign afull  = afull_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign ovf    = ovf_q;

endmodule

// File: doc/u8acc_pack.md
Name: u8acc_pack

Overview:
- Output stage directly downstream of u8mac.
- Collects the u8 results presented on accd/acvalid and packs them, little-endian, into 32-bit words with byte strobes.
- Buffers packed words in a small FIFO and issues them to the memory writer over a valid/ready channel.
- Tracks the byte address and remaining length, signals completion, and raises an almost-full flag so the sequencer can throttle u8mac via rdy.

Parameters:
- AW, 24, byte address width.
- DEPTH, 8, FIFO depth in words; power of 2, at least 2.
- AFULL, 2, afull asserts when free FIFO entries <= AFULL.

Ports:
- clk  in  1  clock
- xreset  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches base_adr and out_len
- base_adr  in  AW  byte start address; may be unaligned
- out_len  in  AW  number of bytes to write
- acvalid  in  1  accd valid (from u8mac)
- accd  in  8  u8 result byte (from u8mac)
- wvalid  out  1  write request valid
- wready  in  1  write accepted
- wadr  out  AW-2  word address
- wdata  out  32  packed data; byte k on bits [8k+7:8k]
- wstrb  out  4  byte enables
- afull  out  1  FIFO free entries <= AFULL
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- ovf  out  1  sticky overflow; a word was dropped

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low (xreset low at a clk rising edge).
  - All outputs are 0.
  - State returns to IDLE.
  - FIFO is emptied, and the pack register and strobes are cleared.
  - Reset asserted mid-operation discards all buffered data.
- States are IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start: adr <= base_adr, remain <= out_len, ovf <= 0.
  - If out_len != 0, go to RUN.
  - If out_len == 0, go to DONE.
  - acvalid is ignored in IDLE.
- start outside IDLE is ignored.
- RUN, on acvalid:
  - lane = adr[1:0]; pack[lane] <= accd; strb[lane] <= 1.
  - adr++ and remain-- (AW-bit, wraps modulo 2^AW).
  - Word completes when lane == 3 or remain == 1 before the decrement (last byte).
  - On completion, {adr[AW-1:2], pack with the new byte merged, strb} is pushed into the FIFO in the same cycle, and pack/strb clear.
  - After the last byte, go to FLUSH.
- Push when full:
  - If the FIFO is full and no pop occurs in the same cycle, the word is dropped and ovf <= 1.
  - Push and pop in the same cycle while full is legal: count unchanged, no ovf.
- FLUSH:
  - Wait for FIFO empty, then go to DONE.
  - acvalid is ignored.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- Output channel:
  - wvalid = FIFO not empty.
  - wadr, wdata, wstrb come from the FIFO head.
  - A pop occurs on wvalid & wready.
  - Head fields are stable while wvalid & !wready.
- Latency:
  - A byte completing a word at edge N, with the FIFO empty, gives wvalid = 1 after edge N (registered FIFO count).
  - done is asserted the cycle after the last pop.
- afull: registered from the FIFO count; updates the cycle after each push/pop.
- Unaligned start: the first word carries strobes only from lane base_adr[1:0] upward.
- Short end: the last word carries strobes only up to the final lane.
- ovf holds until the next accepted start or reset.

Test Plan:
- Aligned run: base_adr=0x100, out_len=8, accd=01..08 on consecutive cycles, wready=1 -> two writes: wadr=0x40 wdata=0x04030201 wstrb=F, then wadr=0x41 wdata=0x08070605 wstrb=F; done pulses once; ovf=0.
- Unaligned run: base_adr=0x103, out_len=3, accd=AA,BB,CC -> wadr=0x40 wdata[31:24]=AA wstrb=8, then wadr=0x41 wdata[15:0]=0xCCBB wstrb=3; other strobes 0.
- Backpressure: wready=0, 36 aligned bytes (9 words), DEPTH=8 -> afull=1 once 6 words are queued; 9th word dropped with ovf=1; then wready=1 -> exactly 8 writes in order; done after the 8th pop; ovf stays 1.
- Full with simultaneous pop: FIFO full, wready=1 in the same cycle as a word-completing acvalid -> count unchanged, ovf=0, no data lost.
- Zero length: start with out_len=0 -> done=1 on the cycle after start, wvalid never asserted, busy returns to 0.
- Reset mid-RUN: xreset=0 after 5 bytes -> all outputs 0 after the edge and FIFO empty; a new start with base_adr=0, out_len=4 then produces a single correct write.
